// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache and D-cache: one owner per transaction,
// outstanding reads are drained before ownership changes, returns routed to the owner.
module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_busy,
    input  logic        ic_mem_read,
    input  logic [15:0] ic_mem_addr,
    output logic        ic_grant,
    output logic        ic_ready,
    output logic        ic_mem_valid,
    output logic [15:0] ic_mem_data,
    input  logic        dc_busy,
    input  logic        dc_mem_read,
    input  logic        dc_mem_write,
    input  logic [15:0] dc_mem_addr,
    input  logic [15:0] dc_mem_wdata,
    output logic        dc_grant,
    output logic        dc_ready,
    output logic        dc_mem_valid,
    output logic [15:0] dc_mem_data,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        protocol_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN_I = 2'd1;
    localparam logic [1:0] S_OWN_D = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state;
    logic             owner_d;
    logic             last_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rd_acc;
    logic             ret_ok;

    assign ic_grant = (state == S_OWN_I);
    assign dc_grant = (state == S_OWN_D);
    assign ic_ready = ic_grant && (cnt < CNT_W'(MAX_OUTSTANDING));
    assign dc_ready = dc_grant && (cnt < CNT_W'(MAX_OUTSTANDING));

    // A D-cache write takes priority over a simultaneous read; that read is dropped.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_acc    = 1'b0;
        if (ic_ready && ic_mem_read) begin
            mem_en   = 1'b1;
            mem_addr = ic_mem_addr;
            rd_acc   = 1'b1;
        end else if (dc_ready && (dc_mem_read || dc_mem_write)) begin
            mem_en   = 1'b1;
            mem_wr   = dc_mem_write;
            mem_addr = dc_mem_addr;
            if (dc_mem_write) begin
                mem_wdata = dc_mem_wdata;
            end else begin
                rd_acc = 1'b1;
            end
        end
    end

    // Returns with nothing outstanding are stray and never forwarded.
    assign ret_ok       = mem_rvalid && (cnt != '0);
    assign ic_mem_valid = ret_ok && !owner_d;
    assign dc_mem_valid = ret_ok && owner_d;
    assign ic_mem_data  = ic_mem_valid ? mem_rdata : '0;
    assign dc_mem_data  = dc_mem_valid ? mem_rdata : '0;

    always_comb begin
        cnt_nxt = cnt;
        if (rd_acc && !ret_ok) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (!rd_acc && ret_ok) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            owner_d      <= 1'b0;
            last_d       <= 1'b0;
            cnt          <= '0;
            protocol_err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (mem_rvalid && (cnt == '0)) begin
                protocol_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (ic_busy && dc_busy) begin
                        owner_d <= !last_d;
                        state   <= last_d ? S_OWN_I : S_OWN_D;
                    end else if (ic_busy) begin
                        owner_d <= 1'b0;
                        state   <= S_OWN_I;
                    end else if (dc_busy) begin
                        owner_d <= 1'b1;
                        state   <= S_OWN_D;
                    end
                end
                S_OWN_I: begin
                    if (!ic_busy) begin
                        last_d <= 1'b0;
                        state  <= (cnt_nxt == '0) ? S_IDLE : S_DRAIN;
                    end
                end
                S_OWN_D: begin
                    if (!dc_busy) begin
                        last_d <= 1'b1;
                        state  <= (cnt_nxt == '0) ? S_IDLE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cnt_nxt == '0) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; returned data checked through a scoreboard queue.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_busy, ic_mem_read;
    logic [15:0] ic_mem_addr;
    logic        ic_grant, ic_ready, ic_mem_valid;
    logic [15:0] ic_mem_data;
    logic        dc_busy, dc_mem_read, dc_mem_write;
    logic [15:0] dc_mem_addr, dc_mem_wdata;
    logic        dc_grant, dc_ready, dc_mem_valid;
    logic [15:0] dc_mem_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rvalid;
    logic        protocol_err;

    mem_arbiter #(.MAX_OUTSTANDING(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ic_busy(ic_busy), .ic_mem_read(ic_mem_read), .ic_mem_addr(ic_mem_addr),
        .ic_grant(ic_grant), .ic_ready(ic_ready), .ic_mem_valid(ic_mem_valid),
        .ic_mem_data(ic_mem_data),
        .dc_busy(dc_busy), .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
        .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
        .dc_grant(dc_grant), .dc_ready(dc_ready), .dc_mem_valid(dc_mem_valid),
        .dc_mem_data(dc_mem_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        own_d;
        logic [15:0] dat;
    } exp_t;

    exp_t        sb[$];
    int          rq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_cnt = 0;
    logic        resp_on = 1'b0;
    logic [15:0] resp_val = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic own_d, input logic [15:0] dat);
        exp_t e;
        e.own_d = own_d;
        e.dat   = dat;
        sb.push_back(e);
    endtask

    // One clock step; memory model answers reads 4 cycles after acceptance.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc_cnt++;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rq.size() > 0 && rq[0] == cyc_cnt) begin
            void'(rq.pop_front());
            mem_rvalid = 1'b1;
            mem_rdata  = resp_val;
            resp_val   = resp_val + 16'd1;
        end
    endtask

    always @(negedge clk) begin
        if (resp_on && mem_en && !mem_wr) rq.push_back(cyc_cnt + 4);
    end

    always @(negedge clk) begin
        if (ic_mem_valid || dc_mem_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_return: ic_v=%0b dc_v=%0b with nothing expected",
                         ic_mem_valid, dc_mem_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ret_to_dc", {31'd0, dc_mem_valid}, {31'd0, e.own_d});
                chk("ret_to_ic", {31'd0, ic_mem_valid}, {31'd0, !e.own_d});
                chk("ret_data", {16'd0, (e.own_d ? dc_mem_data : ic_mem_data)}, {16'd0, e.dat});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ic_busy = 0; ic_mem_read = 0; ic_mem_addr = '0;
        dc_busy = 0; dc_mem_read = 0; dc_mem_write = 0; dc_mem_addr = '0; dc_mem_wdata = '0;
        mem_rvalid = 0; mem_rdata = '0;
        repeat (3) cycle();
        @(negedge clk);
        chk("rst_grants", {30'd0, ic_grant, dc_grant}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_perr", {31'd0, protocol_err}, 32'd0);
        cycle(); rst = 1'b1;

        // I-cache block fill
        cycle(); ic_busy = 1;
        @(negedge clk); chk("t1_grant_idle", {31'd0, ic_grant}, 32'd0);
        cycle();
        @(negedge clk); chk("t1_ic_grant", {31'd0, ic_grant}, 32'd1);
        chk("t1_dc_grant", {31'd0, dc_grant}, 32'd0);
        resp_on = 1; resp_val = 16'd1;
        for (int i = 0; i < 8; i++) push(1'b0, 16'(i + 1));
        for (int i = 0; i < 8; i++) begin
            cycle(); ic_mem_read = 1; ic_mem_addr = 16'h0010 + 16'(i);
            @(negedge clk);
            chk("t1_ready", {31'd0, ic_ready}, 32'd1);
            chk("t1_mem_en", {30'd0, mem_en, mem_wr}, 32'd2);
            chk("t1_addr", {16'd0, mem_addr}, 32'h0010 + i);
        end
        cycle(); ic_mem_read = 0;
        repeat (5) cycle();
        chk("t1_sb_empty", sb.size(), 0);
        ic_busy = 0;
        cycle(); cycle();
        @(negedge clk); chk("t1_idle", {31'd0, ic_grant}, 32'd0);
        chk("t1_perr", {31'd0, protocol_err}, 32'd0);
        resp_on = 0;

        // Simultaneous request after reset, then round-robin
        cycle(); rst = 0;
        cycle(); rst = 1;
        cycle(); ic_busy = 1; dc_busy = 1;
        @(negedge clk); chk("t2_none_yet", {30'd0, ic_grant, dc_grant}, 32'd0);
        cycle(); ic_mem_read = 1; ic_mem_addr = 16'h0099;
        @(negedge clk);
        chk("t2_dc_first", {30'd0, ic_grant, dc_grant}, 32'd1);
        chk("t2_ic_ready", {31'd0, ic_ready}, 32'd0);
        chk("t2_nonowner_ign", {31'd0, mem_en}, 32'd0);
        cycle();
        @(negedge clk); chk("t2_ic_waits", {30'd0, ic_grant, dc_grant}, 32'd1);
        cycle(); ic_busy = 0; dc_busy = 0; ic_mem_read = 0;
        @(negedge clk); chk("t2_dc_hold", {31'd0, dc_grant}, 32'd1);
        cycle();
        @(negedge clk); chk("t2_idle", {30'd0, ic_grant, dc_grant}, 32'd0);
        cycle(); ic_busy = 1; dc_busy = 1;
        cycle();
        @(negedge clk); chk("t2_rr_ic", {30'd0, ic_grant, dc_grant}, 32'd2);

        // Drain: D-cache releases with three reads in flight
        cycle(); ic_busy = 0;
        cycle();
        @(negedge clk); chk("t3_idle", {30'd0, ic_grant, dc_grant}, 32'd0);
        cycle();
        @(negedge clk); chk("t3_dc_grant", {31'd0, dc_grant}, 32'd1);
        resp_on = 1; resp_val = 16'h00D1;
        for (int i = 0; i < 3; i++) push(1'b1, 16'h00D1 + 16'(i));
        for (int i = 0; i < 3; i++) begin
            cycle(); dc_mem_read = 1; dc_mem_addr = 16'h0030 + 16'(i);
            @(negedge clk); chk("t3_addr", {15'd0, mem_en, mem_addr}, 32'h10030 + i);
        end
        cycle(); dc_mem_read = 0; dc_busy = 0; ic_busy = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            @(negedge clk); chk("t3_drain_nogrant", {30'd0, ic_grant, dc_grant}, 32'd0);
        end
        cycle();
        @(negedge clk); chk("t3_idle_after", {31'd0, ic_grant}, 32'd0);
        cycle();
        @(negedge clk); chk("t3_ic_grant", {31'd0, ic_grant}, 32'd1);
        chk("t3_sb_empty", sb.size(), 0);
        resp_on = 0;

        // Outstanding cap
        cycle(); ic_busy = 0; dc_busy = 1;
        cycle(); cycle();
        @(negedge clk); chk("t4_dc_grant", {31'd0, dc_grant}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            cycle(); dc_mem_read = 1; dc_mem_addr = 16'h0100 + 16'(i);
            @(negedge clk);
            chk("t4_ready", {31'd0, dc_ready}, (i < 8) ? 32'd1 : 32'd0);
            chk("t4_mem_en", {31'd0, mem_en}, (i < 8) ? 32'd1 : 32'd0);
        end
        push(1'b1, 16'h4000);
        cycle(); dc_mem_read = 0; mem_rvalid = 1; mem_rdata = 16'h4000;
        @(negedge clk); chk("t4_full_ready", {31'd0, dc_ready}, 32'd0);
        cycle();
        @(negedge clk); chk("t4_ready_again", {31'd0, dc_ready}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            push(1'b1, 16'h4000 + 16'(i));
            cycle(); mem_rvalid = 1; mem_rdata = 16'h4000 + 16'(i);
        end

        // D-cache write-through, then write+read collision
        cycle(); mem_rvalid = 0; dc_mem_write = 1; dc_mem_addr = 16'h0040; dc_mem_wdata = 16'hBEEF;
        @(negedge clk);
        chk("t5_en_wr", {30'd0, mem_en, mem_wr}, 32'd3);
        chk("t5_addr", {16'd0, mem_addr}, 32'h0040);
        chk("t5_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        cycle(); dc_mem_read = 1; dc_mem_addr = 16'h0041; dc_mem_wdata = 16'h1234;
        @(negedge clk);
        chk("t5_wr_wins", {14'd0, mem_en, mem_wr, mem_addr}, 32'h30041);
        cycle(); dc_mem_read = 0; dc_mem_write = 0; dc_busy = 0;
        @(negedge clk); chk("t5_dc_hold", {31'd0, dc_grant}, 32'd1);
        cycle(); ic_busy = 1;
        @(negedge clk); chk("t5_idle", {30'd0, ic_grant, dc_grant}, 32'd0);
        cycle();
        @(negedge clk); chk("t5_direct_idle", {31'd0, ic_grant}, 32'd1);

        // Reset mid-fill, then a stray return
        for (int i = 0; i < 3; i++) begin
            cycle(); ic_mem_read = 1; ic_mem_addr = 16'h0200 + 16'(i);
            @(negedge clk); chk("t6_mem_en", {31'd0, mem_en}, 32'd1);
        end
        cycle(); rst = 0;
        @(negedge clk);
        chk("t6_rst_grant", {30'd0, ic_grant, dc_grant}, 32'd0);
        chk("t6_rst_en", {30'd0, mem_en, ic_ready}, 32'd0);
        chk("t6_rst_perr", {31'd0, protocol_err}, 32'd0);
        cycle(); rst = 1; ic_busy = 0; ic_mem_read = 0;
        cycle(); mem_rvalid = 1; mem_rdata = 16'h5555;
        @(negedge clk);
        chk("t6_no_valid", {30'd0, ic_mem_valid, dc_mem_valid}, 32'd0);
        chk("t6_no_data", {ic_mem_data, dc_mem_data}, 32'd0);
        cycle();
        @(negedge clk); chk("t6_perr", {31'd0, protocol_err}, 32'd1);
        cycle();
        @(negedge clk); chk("t6_perr_sticky", {31'd0, protocol_err}, 32'd1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_drain: %0d returns never seen, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified memory port between the I-cache (read-only fills) and the D-cache (fills plus write-through stores).
- Sits between both CACHE instances' memory-side signals (cache_MemRead, cache_MemWrite, cache_mem_addr, MemDataValid, mem_read_data) and the multi-cycle memory module.
- Grants one owner per transaction, tracks outstanding reads and drains them before switching owners.
- Routes returned data to the owner that issued the reads.

Parameters:
- MAX_OUTSTANDING, 8: maximum reads in flight; equals one 8-word block fill.
- CNT_W, 4: outstanding counter width; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ic_busy  in  1  I-cache requests memory ownership (its CacheBusy).
- ic_mem_read  in  1  I-cache read command.
- ic_mem_addr  in  16  I-cache word address.
- ic_grant  out  1  I-cache owns memory.
- ic_ready  out  1  I-cache command accepted this cycle if asserted.
- ic_mem_valid  out  1  returned data valid for I-cache.
- ic_mem_data  out  16  returned data for I-cache.
- dc_busy  in  1  D-cache requests ownership.
- dc_mem_read  in  1  D-cache read command.
- dc_mem_write  in  1  D-cache write command.
- dc_mem_addr  in  16  D-cache word address.
- dc_mem_wdata  in  16  D-cache write data.
- dc_grant  out  1  D-cache owns memory.
- dc_ready  out  1  D-cache command accepted if asserted.
- dc_mem_valid  out  1  returned data valid for D-cache.
- dc_mem_data  out  16  returned data for D-cache.
- mem_en  out  1  memory command strobe.
- mem_wr  out  1  1 = write, 0 = read (valid with mem_en).
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_rvalid  in  1  mem_rdata valid, one word per cycle.
- protocol_err  out  1  sticky: mem_rvalid seen with zero reads outstanding.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, outstanding = 0, last_owner = I. All outputs 0: grants, ready, valids, data, mem_*, protocol_err.
- States: IDLE, OWN_I, OWN_D, DRAIN. owner register is I or D.
- IDLE:
  - If only one busy is high, go to OWN_x for that requester.
  - If both are high, grant the requester that is not last_owner. After reset this means D-cache wins first.
  - Grant registers: busy sampled at edge N gives grant high from edge N+1. No command is issued in the IDLE cycle.
- OWN_x:
  - x_grant = 1.
  - x_ready = (outstanding < MAX_OUTSTANDING).
  - Command accepted when x_ready & (read | write). mem_en/mem_wr/mem_addr/mem_wdata are driven combinationally from the owner's signals that same cycle.
  - Non-owner command inputs are ignored. Non-owner ready = 0.
  - dc_mem_read & dc_mem_write both high: write wins, and the read is not counted.
  - When x_busy falls: set last_owner = x. Go to IDLE if outstanding == 0 (after this cycle's update), otherwise go to DRAIN. Grant drops on the same edge.
- DRAIN:
  - No grant, no commands.
  - Wait until outstanding reaches 0, then go to IDLE.
  - A new busy raised during DRAIN waits, with no grant.
- Outstanding counter:
  - +1 on each accepted read; −1 on each mem_rvalid; net 0 when both happen in one cycle.
  - Writes are not counted.
  - Never exceeds MAX_OUTSTANDING, enforced via ready.
- Read return routing:
  - mem_rvalid is routed to the owner register, valid in both OWN and DRAIN.
  - x_mem_valid = mem_rvalid & owner==x, combinational. x_mem_data = mem_rdata when valid, else 0.
- mem_rvalid with outstanding == 0:
  - Counter stays 0.
  - Data is not forwarded to either cache.
  - protocol_err set, cleared only by reset.
- Reset mid-burst: everything is cleared immediately. Returns still in flight after reset are flagged by protocol_err.

Test Plan:
1. I-cache fill:
   - Stimulus: ic_busy=1, then 8 reads at 0x0010..0x0017; memory returns 1..8 at 4-cycle latency.
   - Required: ic_grant one cycle after busy; mem_addr mirrors each read; ic_mem_valid pulses 8 times with data 1..8; dc_mem_valid stays 0.
2. Simultaneous request after reset:
   - Stimulus: ic_busy=dc_busy=1 on the same edge.
   - Required: dc_grant first. ic_grant only after dc_busy falls and outstanding==0. Repeat both → ic is granted next (round-robin).
3. Drain:
   - Stimulus: dc_busy falls with 3 reads outstanding while ic_busy=1.
   - Required: state DRAIN; 3 returns delivered to dc_mem_data; ic_grant rises the cycle after IDLE.
4. Outstanding cap:
   - Stimulus: owner issues 9 back-to-back reads with no returns.
   - Required: dc_ready=0 after the 8th; mem_en=0 on the 9th. One mem_rvalid → ready=1 again.
5. D-cache write-through:
   - Stimulus: dc_mem_write, addr 0x0040, data 0xBEEF.
   - Required: mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF in the same cycle; outstanding unchanged; busy falling → IDLE directly.
6. Reset/error:
   - Stimulus: rst low mid-fill.
   - Required: grants, mem_en and valids are 0 immediately. A following mem_rvalid → protocol_err=1, no valid to either cache.
